// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input and instruction-memory write port of the program loader.
//   Bundle side : in_valid/in_ready handshake with fmt, opcode, rs, rt, rd, func, imm.
//   Memory side : mem_wr/mem_ready handshake with mem_addr (AW bits) and mem_data (16 bits).
// slave  : the loader (consumes bundles, drives the memory write port).
// master : the environment (produces bundles, acts as the memory).
interface instr_encoder_loader_if #(
    parameter int unsigned AW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [4:0]    opcode;
    logic [2:0]    rs;
    logic [2:0]    rt;
    logic [2:0]    rd;
    logic [1:0]    func;
    logic [10:0]   imm;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_ready;

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, func, imm, mem_ready,
        output in_ready, mem_wr, mem_addr, mem_data
    );

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, func, imm, mem_ready,
        input  in_ready, mem_wr, mem_addr, mem_data
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Program loader: packs decoded instruction fields into 16-bit WISC-SP22 words, buffers them
// in a small FIFO and writes them to consecutive instruction-memory addresses.
//   clk_i       : clock, all state on rising edge
//   rst_i       : synchronous active-high reset
//   start_i     : one-cycle pulse, latches base_addr_i and begins a load (IDLE/DONE only)
//   base_addr_i : first write address
//   bus         : bundle handshake + memory write port (slave modport)
//   busy_o      : load in progress (RUN or DRAIN)
//   done_o      : load finished, held until next start or reset
//   count_o     : words written since start
module instr_encoder_loader #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [AW-1:0]          base_addr_i,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [AW-1:0]          count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [15:0]   fifo_q [DEPTH];
    logic [PtrW:0] wptr_q, rptr_q;
    logic [PtrW:0] occ;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] count_q;
    logic [15:0]   pack_word;
    logic          fifo_full, fifo_empty, fifo_one;
    logic          push, pop, load;
    logic          in_ready, mem_wr;

    // Pointers carry one extra wrap bit; occupancy never exceeds DEPTH, so its MSB marks full.
    assign occ        = wptr_q - rptr_q;
    assign fifo_full  = occ[PtrW];
    assign fifo_empty = (occ == '0);
    assign fifo_one   = (occ == {{PtrW{1'b0}}, 1'b1});

    assign push = bus.in_valid && in_ready;
    assign pop  = mem_wr && bus.mem_ready;
    assign load = start_i && ((state_q == StIdle) || (state_q == StDone));

    // Field packing; unused immediate bits are dropped.
    always_comb begin
        pack_word = '0;
        unique case (bus.fmt)
            2'b00: pack_word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.func};
            2'b01: pack_word = {bus.opcode, bus.rs, bus.rd, bus.imm[4:0]};
            2'b10: pack_word = {bus.opcode, bus.rs, bus.imm[7:0]};
            2'b11: pack_word = {bus.opcode, bus.imm[10:0]};
            default: pack_word = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (push && (bus.opcode == 5'b00000)) state_d = StDrain;
            // The HALT word is still queued on entry, so DRAIN always sees a final pop.
            StDrain: if (pop && fifo_one) state_d = StDone;
            StDone:  if (start_i) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and FIFO status; in_ready deliberately ignores mem_ready.
    always_comb begin
        busy_o   = (state_q == StRun) || (state_q == StDrain);
        done_o   = (state_q == StDone);
        in_ready = (state_q == StRun) && !fifo_full;
        mem_wr   = !fifo_empty && ((state_q == StRun) || (state_q == StDrain));
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_wr   = mem_wr;
    assign bus.mem_addr = waddr_q;
    assign bus.mem_data = mem_wr ? fifo_q[rptr_q[PtrW-1:0]] : 16'h0000;
    assign count_o      = count_q;

    // Pointers, write address and word count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            waddr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (load) begin
                waddr_q <= base_addr_i;
                count_q <= '0;
            end else if (pop) begin
                waddr_q <= waddr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q[PtrW-1:0]] <= pack_word;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: packing formats, backpressure, HALT/DONE
// sequencing, address wrap and mid-load reset. Inputs change on falling edges.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        busy, done;
    logic [15:0] count;

    instr_encoder_loader_if #(.AW(16)) bus ();

    instr_encoder_loader #(.DEPTH(4), .AW(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  op;
        logic [2:0]  rs, rt, rd;
        logic [1:0]  func;
        logic [10:0] imm;
        logic [15:0] word;
    } vec_t;

    vec_t        vecs [7];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_wr_cyc = -1;
    logic        toggle_en = 1'b0;
    logic [15:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    // Write monitor: records every accepted memory write.
    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.mem_wr && bus.mem_ready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_data);
            last_wr_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (toggle_en) bus.mem_ready = ~bus.mem_ready;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic start_load(input logic [15:0] base);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Present a bundle and hold it until accepted; returns on the falling edge after acceptance.
    task automatic send(input int idx);
        bit ok = 1'b0;
        bus.fmt    = vecs[idx].fmt;
        bus.opcode = vecs[idx].op;
        bus.rs     = vecs[idx].rs;
        bus.rt     = vecs[idx].rt;
        bus.rd     = vecs[idx].rd;
        bus.func   = vecs[idx].func;
        bus.imm    = vecs[idx].imm;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 40 && wr_addr_q.size() < n; i++) @(negedge clk);
        check_eq("write_count", wr_addr_q.size(), n);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] base, input int idx0,
                                input int n);
        logic [15:0] a;
        if (wr_addr_q.size() < n) return;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            check_eq({tag, "_addr"}, wr_addr_q[i], a);
            check_eq({tag, "_data"}, wr_data_q[i], vecs[idx0 + i].word);
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                // Done must rise on the same edge that completed the final write.
                check_eq("done_after_last_write", last_wr_cyc, cyc);
                break;
            end
        end
        if (!ok) check_eq("done_timeout", 0, 1);
    endtask

    initial begin
        // fmt, op, rs, rt, rd, func, imm, packed word (hand-computed)
        vecs[0] = '{2'b00, 5'b11011, 3'd1, 3'd2, 3'd3, 2'b00, 11'h000, 16'hD94C};
        vecs[1] = '{2'b01, 5'b01000, 3'd2, 3'd0, 3'd5, 2'b00, 11'h7FF, 16'h42BF};
        vecs[2] = '{2'b10, 5'b11000, 3'd4, 3'd0, 3'd0, 2'b00, 11'h0AB, 16'hC4AB};
        vecs[3] = '{2'b11, 5'b00100, 3'd0, 3'd0, 3'd0, 2'b00, 11'h5A5, 16'h25A5};
        vecs[4] = '{2'b00, 5'b00001, 3'd7, 3'd7, 3'd7, 2'b11, 11'h000, 16'h0FFF};
        vecs[5] = '{2'b10, 5'b10101, 3'd0, 3'd0, 3'd0, 2'b00, 11'h0FF, 16'hA8FF};
        vecs[6] = '{2'b11, 5'b00000, 3'd0, 3'd0, 3'd0, 2'b00, 11'h000, 16'h0000};

        rst = 1'b1;
        start = 1'b0;
        base_addr = 16'h0000;
        bus.in_valid = 1'b0;
        bus.mem_ready = 1'b1;
        bus.fmt = '0; bus.opcode = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.func = '0; bus.imm = '0;
        wait_cycles(2);
        rst = 1'b0;

        // Reset state.
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_mem_wr",   bus.mem_wr,   0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_data", bus.mem_data, 0);
        check_eq("rst_busy",     busy,         0);
        check_eq("rst_done",     done,         0);
        check_eq("rst_count",    count,        0);

        // All four formats, then HALT.
        start_load(16'h0100);
        check_eq("start_busy",     busy,         1);
        check_eq("start_in_ready", bus.in_ready, 1);
        check_eq("start_addr",     bus.mem_addr, 16'h0100);
        send(0);
        check_eq("r_mem_wr",   bus.mem_wr,   1);
        check_eq("r_mem_addr", bus.mem_addr, 16'h0100);
        check_eq("r_mem_data", bus.mem_data, 16'hD94C);
        send(1);
        send(2);
        send(3);
        send(6);
        wait_done();
        wait_writes(5);
        check_writes("fmt", 16'h0100, 0, 4);
        if (wr_data_q.size() == 5) check_eq("fmt_halt_data", wr_data_q[4], 16'h0000);
        check_eq("fmt_count", count, 5);
        check_eq("fmt_busy",  busy,  0);

        // Backpressure: 6 bundles into a 4-deep FIFO with the memory stalled.
        do_reset();
        bus.mem_ready = 1'b0;
        start_load(16'h0010);
        for (int i = 0; i < 4; i++) send(i);
        check_eq("bp_full_in_ready", bus.in_ready, 0);
        bus.fmt = vecs[4].fmt; bus.opcode = vecs[4].op;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq("bp_hold_in_ready", bus.in_ready, 0);
            check_eq("bp_hold_wr",       bus.mem_wr,   1);
            check_eq("bp_hold_addr",     bus.mem_addr, 16'h0010);
            check_eq("bp_hold_data",     bus.mem_data, 16'hD94C);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        send(4);
        send(5);
        wait_writes(6);
        check_writes("bp", 16'h0010, 0, 6);
        check_eq("bp_count", count, 6);

        // HALT as third bundle with the memory toggling ready.
        do_reset();
        bus.mem_ready = 1'b0;
        toggle_en = 1'b1;
        start_load(16'h0040);
        send(0);
        send(1);
        send(6);
        check_eq("halt_in_ready", bus.in_ready, 0);
        check_eq("halt_busy",     busy,         1);
        wait_done();
        toggle_en = 1'b0;
        bus.mem_ready = 1'b1;
        check_writes("halt", 16'h0040, 0, 2);
        check_eq("halt_nwrites", wr_addr_q.size(), 3);
        check_eq("halt_count",   count, 3);
        check_eq("halt_busy_end", busy, 0);
        check_eq("halt_done_held", done, 1);

        // Address wrap-around.
        do_reset();
        start_load(16'hFFFF);
        send(2);
        send(3);
        wait_writes(2);
        check_writes("wrap", 16'hFFFF, 2, 2);
        check_eq("wrap_count", count, 2);

        // Reset with three words queued and the memory stalled.
        do_reset();
        bus.mem_ready = 1'b0;
        start_load(16'h0200);
        send(0);
        send(1);
        send(2);
        check_eq("mid_mem_wr", bus.mem_wr, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_mem_wr",   bus.mem_wr,   0);
        check_eq("mid_rst_in_ready", bus.in_ready, 0);
        check_eq("mid_rst_addr",     bus.mem_addr, 0);
        check_eq("mid_rst_data",     bus.mem_data, 0);
        check_eq("mid_rst_busy",     busy,         0);
        check_eq("mid_rst_count",    count,        0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        start_load(16'h0300);
        send(3);
        wait_cycles(5);
        check_eq("post_rst_nwrites", wr_addr_q.size(), 1);
        check_writes("post_rst", 16'h0300, 3, 1);
        check_eq("post_rst_count", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
